// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked inter-stage pipeline register with a 2-entry skid buffer.
// The payload is split into a control field and a data field.
// A bubble or a flush forces the control field to CTRL_RST and leaves the data field unchanged.
// Optional feature: define PIPE_STAGE_REG_PERF_EN to add the stall_cnt and flush_cnt counters.
module pipe_stage_reg #(
  parameter int unsigned         CTRL_W   = 16,
  parameter int unsigned         DATA_W   = 128,
  parameter logic [CTRL_W-1:0]   CTRL_RST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
`ifdef PIPE_STAGE_REG_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  // State encoding is {skid_valid, main_valid}
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;
  logic [1:0]        occ_q, occ_d;
  logic              acc, drn;

  assign acc = in_valid & in_ready_q;
  assign drn = state_q[0] & out_ready;

  // Next-state and next-entry computation; flush overrides every transition
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          state_d     = BUSY;
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end
      end
      BUSY: begin
        if (acc && drn) begin
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end else if (acc) begin
          state_d     = FULL;
          skid_ctrl_d = in_ctrl;
          skid_data_d = in_data;
        end else if (drn) begin
          state_d     = EMPTY;
          main_ctrl_d = CTRL_RST;
        end
      end
      FULL: begin
        if (drn) begin
          state_d     = BUSY;
          main_ctrl_d = skid_ctrl_q;
          main_data_d = skid_data_q;
          skid_ctrl_d = CTRL_RST;
        end
      end
      default: begin
        state_d     = EMPTY;
        main_ctrl_d = CTRL_RST;
        skid_ctrl_d = CTRL_RST;
      end
    endcase
    // Data fields keep their old value so that a killed payload is never visible
    if (flush) begin
      state_d     = EMPTY;
      main_ctrl_d = CTRL_RST;
      main_data_d = main_data_q;
      skid_ctrl_d = CTRL_RST;
      skid_data_d = skid_data_q;
    end
    in_ready_d = ~state_d[1];
    occ_d      = 2'(state_d[1]) + 2'(state_d[0]);
  end

  // State and entry registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_ctrl_q <= CTRL_RST;
      main_data_q <= '0;
      skid_ctrl_q <= CTRL_RST;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
      occ_q       <= occ_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = state_q[0];
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign occ       = occ_q;

`ifdef PIPE_STAGE_REG_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // Count stalled cycles and flushes that actually kill entries; both counters wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (state_q[0] && !out_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush && (occ_q != 2'd0)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random checks of pipe_stage_reg against a queue-based reference model.
module tb_pipe_stage_reg;

  localparam int unsigned CTRL_W = 16;
  localparam int unsigned DATA_W = 128;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occ;
`ifdef PIPE_STAGE_REG_PERF_EN
  logic [31:0]       stall_cnt, flush_cnt;
`endif

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CTRL_RST('0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occ       (occ)
`ifdef PIPE_STAGE_REG_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } ent_t;

  // Reference model: an in-order FIFO of at most two payloads
  ent_t              mq[$];
  logic [DATA_W-1:0] m_data;
  int unsigned       m_stall, m_flush;
  int                n_vec = 0;
  int                n_err = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_data  = '0;
    m_stall = 0;
    m_flush = 0;
  endtask

  // Advance model and DUT by one clock, then compare every output against the model
  task automatic step();
    bit a, d;
    ent_t e;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      a = in_valid && (mq.size() < 2);
      d = (mq.size() > 0) && out_ready;
      if (mq.size() > 0 && !out_ready) m_stall++;
      if (flush && mq.size() > 0) m_flush++;
      if (flush) begin
        mq.delete();
      end else begin
        if (d) void'(mq.pop_front());
        if (a) begin
          e.c = in_ctrl;
          e.d = in_data;
          mq.push_back(e);
        end
        if (mq.size() > 0) m_data = mq[0].d;
      end
    end
    @(negedge clk);
    chk("out_valid", DATA_W'(out_valid), DATA_W'(mq.size() > 0));
    chk("out_ctrl", DATA_W'(out_ctrl), (mq.size() > 0) ? DATA_W'(mq[0].c) : '0);
    chk("out_data", out_data, m_data);
    chk("in_ready", DATA_W'(in_ready), DATA_W'(mq.size() < 2));
    chk("occ", DATA_W'(occ), DATA_W'(mq.size()));
`ifdef PIPE_STAGE_REG_PERF_EN
    chk("stall_cnt", DATA_W'(stall_cnt), DATA_W'(m_stall));
    chk("flush_cnt", DATA_W'(flush_cnt), DATA_W'(m_flush));
`endif
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] dd);
    in_valid = v;
    in_ctrl  = c;
    in_data  = dd;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    model_reset();
    step();
    step();
    rst = 1'b0;
    chk("rst_in_ready", DATA_W'(in_ready), DATA_W'(1));
    chk("rst_occ", DATA_W'(occ), '0);

    // Streaming 1..8 back-to-back
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, CTRL_W'(i), DATA_W'(i));
      step();
      chk("stream_data", out_data, DATA_W'(i));
      chk("stream_in_ready", DATA_W'(in_ready), DATA_W'(1));
    end
    drive(1'b0, '0, '0);
    step();

    // Skid fill then drain
    drive(1'b1, 16'h0003, DATA_W'(32'hA));
    step();
    out_ready = 1'b0;
    drive(1'b1, 16'h0005, DATA_W'(32'hB));
    step();
    chk("skid_occ", DATA_W'(occ), DATA_W'(2));
    chk("skid_in_ready", DATA_W'(in_ready), '0);
    chk("skid_data_a", out_data, DATA_W'(32'hA));
    drive(1'b0, '0, '0);
    step();
    chk("skid_stable_a", out_data, DATA_W'(32'hA));
    out_ready = 1'b1;
    step();
    chk("skid_drain_b", out_data, DATA_W'(32'hB));
    step();
    chk("skid_empty", DATA_W'(occ), '0);

    // Flush while FULL with a payload offered in the flush cycle
    out_ready = 1'b0;
    drive(1'b1, 16'h0011, DATA_W'(32'h1));
    step();
    drive(1'b1, 16'h0022, DATA_W'(32'h2));
    step();
    drive(1'b1, 16'h0033, DATA_W'(32'hC));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_valid", DATA_W'(out_valid), '0);
    chk("flush_ctrl", DATA_W'(out_ctrl), '0);
    chk("flush_occ", DATA_W'(occ), '0);
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    step();
    chk("flush_no_c", DATA_W'(out_data != DATA_W'(32'hC)), DATA_W'(1));

    // Bubble keeps data and zeroes control
    drive(1'b1, 16'hABCD, DATA_W'(32'h55));
    step();
    drive(1'b0, '0, '0);
    step();
    chk("bubble_valid", DATA_W'(out_valid), '0);
    chk("bubble_ctrl", DATA_W'(out_ctrl), '0);
    chk("bubble_data", out_data, DATA_W'(32'h55));

`ifdef PIPE_STAGE_REG_PERF_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 16'h0001, DATA_W'(32'h77));
    step();
    drive(1'b0, '0, '0);
    for (int i = 0; i < 5; i++) step();
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    step();
    flush = 1'b0;
    chk("perf_stall", DATA_W'(stall_cnt), DATA_W'(5));
    chk("perf_flush", DATA_W'(flush_cnt), DATA_W'(1));
`endif

    // Reset asserted mid-cycle while holding two entries and offering a payload
    out_ready = 1'b0;
    drive(1'b1, 16'h0101, DATA_W'(32'h9));
    step();
    step();
    drive(1'b1, 16'h00FF, DATA_W'(32'hEE));
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", DATA_W'(out_valid), '0);
    chk("rst_async_ctrl", DATA_W'(out_ctrl), '0);
    chk("rst_async_data", out_data, '0);
    chk("rst_async_in_ready", DATA_W'(in_ready), DATA_W'(1));
    chk("rst_async_occ", DATA_W'(occ), '0);
    step();
    rst = 1'b0;
    drive(1'b0, '0, '0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 2) != 0), CTRL_W'($urandom),
            {$urandom, $urandom, $urandom, $urandom});
      out_ready = 1'($urandom_range(0, 3) != 0);
      flush     = 1'($urandom_range(0, 15) == 0);
      rst       = 1'($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    flush = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, handshaked pipeline stage register for the PCPU datapath.
- Generalised successor to the fixed-field inter-stage latch: payload is split into a control field and a data field.
- Adds valid/ready flow control with a 2-entry skid buffer, synchronous flush, and bubble insertion that zeroes control bits.
- Instantiated between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB); the hazard unit drives flush and the downstream stall (out_ready).

Parameters:
- CTRL_W, 16, control-field width (MemWrite, RegWrite, ALUOP, ...); forced to zero on bubble/flush.
- DATA_W, 128, data-field width (regdata, ext, pc_add4, reg indices, ...); held on bubble.
- CTRL_RST, 0, reset and bubble value of the control field (CTRL_W bits).

Ports:
- clk  in  1  rising-edge clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream offers a payload.
- in_ready  out  1  stage can accept; registered, equals NOT skid_valid.
- in_ctrl  in  CTRL_W  upstream control field.
- in_data  in  DATA_W  upstream data field.
- flush  in  1  synchronous kill of all held entries (branch/jump redirect).
- out_valid  out  1  main entry valid.
- out_ready  in  1  downstream accepts; low = stall.
- out_ctrl  out  CTRL_W  main control field; CTRL_RST whenever out_valid=0.
- out_data  out  DATA_W  main data field.
- occ  out  2  occupancy: 0, 1 or 2 entries.

Behaviour:
- Storage: main entry (main_valid, main_ctrl, main_data) and skid entry (skid_valid, skid_ctrl, skid_data).
- Reset (async, immediate):
  - main_valid=skid_valid=0; main/skid ctrl=CTRL_RST; data=0.
  - Outputs: in_ready=1, out_valid=0, out_ctrl=CTRL_RST, out_data=0, occ=0.
- Handshakes:
  - acc = in_valid & in_ready.
  - drn = out_valid & out_ready.
  - in_ready and out_valid are both direct register outputs; there is no combinational in->out path.
  - Upstream is not required to hold in_valid; a payload is consumed only on acc.
- States, encoded by {skid_valid, main_valid}:
  - EMPTY (00): acc -> BUSY; main <= input.
  - BUSY (01):
    - acc & drn -> BUSY; main <= input.
    - acc & !drn -> FULL; skid <= input.
    - !acc & drn -> EMPTY.
    - Otherwise hold.
  - FULL (11): in_ready=0, so acc cannot occur.
    - drn -> BUSY; main <= skid; skid_valid <= 0.
    - Otherwise hold both entries.
- Latency and throughput:
  - 1 cycle from acc (EMPTY) to out_valid.
  - Sustained 1 transfer/cycle while out_ready=1.
  - Order always preserved.
- Bubble:
  - When main_valid=0, out_ctrl=CTRL_RST.
  - out_data keeps its last value (no toggle for power).
  - When skid is empty, its contents are don't-care.
- Flush (highest priority, synchronous):
  - Next cycle main_valid=skid_valid=0, ctrl fields=CTRL_RST, occ=0, in_ready=1.
  - A payload accepted in the flush cycle is discarded.
  - A drn in the flush cycle still counts as delivered downstream.
- Stall: with out_ready=0, out_valid/out_ctrl/out_data stay stable until drn.
- Simultaneous flush & rst: rst wins.
- Reset asserted mid-transfer: all entries dropped, no partial update.
- occ = main_valid + skid_valid.

Optional Feature:
- Macro: PIPE_STAGE_REG_PERF_EN.
- Defined:
  - Adds outputs stall_cnt[31:0] and flush_cnt[31:0], both reset to 0.
  - stall_cnt increments each cycle where out_valid & !out_ready.
  - flush_cnt increments each cycle flush=1 while occ!=0.
  - Both wrap from 0xFFFFFFFF to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset sequence:
  - Stimulus: assert rst mid-cycle with in_valid=1, in_ctrl=0x00FF.
  - Required: immediately out_valid=0, out_ctrl=0, out_data=0, in_ready=1, occ=0; nothing captured while rst=1.
- Streaming:
  - Stimulus: out_ready=1; send data 1..8 back-to-back.
  - Required: out_data 1..8 on consecutive cycles, first one cycle after first acc; in_ready stays 1.
- Skid fill:
  - Stimulus: main holds A (ctrl=0x0003); out_ready=0; send B.
  - Required: occ=2, in_ready=0, out_data=A stable.
  - Then raise out_ready: A and B delivered in successive cycles, occ back to 0.
- Flush while FULL:
  - Stimulus: occ=2; pulse flush with in_valid=1, data C.
  - Required: next cycle out_valid=0, out_ctrl=0, occ=0, in_ready=1; C never appears at the output.
- Bubble:
  - Stimulus: accept D (ctrl=0xABCD, data=0x55), drain it, then no input.
  - Required: out_valid=0, out_ctrl=0, out_data remains 0x55.
- Perf (PIPE_STAGE_REG_PERF_EN):
  - Stimulus: stall for 5 valid cycles, then flush twice with occ=1.
  - Required: stall_cnt=5, flush_cnt=1; the second flush sees occ=0 and is not counted.
